// File: rtl/snake_core_if.sv
// rtl/snake_core_if.sv - Control, food, pixel-probe and status signals of the snake game core.
interface snake_core_if #(
    parameter int GRID_W  = 64,
    parameter int GRID_H  = 48,
    parameter int MAX_LEN = 16
) ();
    logic                         btn_right;
    logic                         btn_left;
    logic                         btn_up;
    logic                         btn_down;
    logic                         start;
    logic [$clog2(GRID_W)-1:0]    food_x;
    logic [$clog2(GRID_H)-1:0]    food_y;
    logic [9:0]                   x_pos;
    logic [9:0]                   y_pos;
    logic                         food_eaten;
    logic                         game_over;
    logic [$clog2(MAX_LEN+1)-1:0] length;
    logic                         snake_pix;
    logic                         head_pix;

    modport master (
        output btn_right, btn_left, btn_up, btn_down, start,
        output food_x, food_y, x_pos, y_pos,
        input  food_eaten, game_over, length, snake_pix, head_pix
    );

    modport slave (
        input  btn_right, btn_left, btn_up, btn_down, start,
        input  food_x, food_y, x_pos, y_pos,
        output food_eaten, game_over, length, snake_pix, head_pix
    );
endinterface

// File: rtl/snake_core.sv
// rtl/snake_core.sv - Snake game engine: step timer, direction latch, body shift register,
// food/self-collision detection and registered per-pixel body/head hit outputs.
module snake_core #(
    parameter int MAX_LEN     = 16,
    parameter int GRID_W      = 64,
    parameter int GRID_H      = 48,
    parameter int CELL        = 10,
    parameter int STEP_CYCLES = 20000000
) (
    input  logic         clk,
    input  logic         rst,
    snake_core_if.slave  bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam int PW = 16;

    localparam logic [XW-1:0] X_HOME = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_HOME = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_MAX  = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [LW-1:0] L_MAX  = LW'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t          state_q, state_d;
    dir_t            dir_q, dir_d;
    dir_t            pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [XW-1:0]   seg_x_q [MAX_LEN];
    logic [XW-1:0]   seg_x_d [MAX_LEN];
    logic [YW-1:0]   seg_y_q [MAX_LEN];
    logic [YW-1:0]   seg_y_d [MAX_LEN];
    logic            food_eaten_q, food_eaten_d;
    logic            snake_pix_q, snake_pix_d;
    logic            head_pix_q, head_pix_d;

    logic            tick;
    logic            eat;
    logic            hit;
    dir_t            dir_ref;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;
    logic [LW-1:0]   body_lim;
    logic            snake_hit;
    logic            head_hit;

    function automatic logic cell_hit(input logic [PW-1:0] p, input logic [PW-1:0] c);
        logic [PW-1:0] lo;
        lo = c * PW'(CELL);
        return (p >= lo) && (p < lo + PW'(CELL));
    endfunction

    always_comb begin
        tick = (state_q == S_RUN) && (cnt_q == C_LAST);
        nx   = seg_x_q[0];
        ny   = seg_y_q[0];
        case (pend_q)
            D_RIGHT: nx = (seg_x_q[0] == X_MAX)   ? '0    : seg_x_q[0] + XW'(1);
            D_LEFT:  nx = (seg_x_q[0] == '0)      ? X_MAX : seg_x_q[0] - XW'(1);
            D_UP:    ny = (seg_y_q[0] == '0)      ? Y_MAX : seg_y_q[0] - YW'(1);
            default: ny = (seg_y_q[0] == Y_MAX)   ? '0    : seg_y_q[0] + YW'(1);
        endcase
        eat = (nx == bus.food_x) && (ny == bus.food_y);
        // The tail cell is vacated by the move unless the snake grows this step.
        body_lim = eat ? len_q : len_q - LW'(1);
        hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < body_lim) && (nx == seg_x_q[i]) && (ny == seg_y_q[i])) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        seg_x_d      = seg_x_q;
        seg_y_d      = seg_y_q;
        food_eaten_d = 1'b0;
        // On the tick cycle the pending value becomes the committed direction,
        // so a fresh request is filtered against that one instead.
        dir_ref      = tick ? pend_q : dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (bus.btn_right && dir_ref != D_LEFT)       pend_d = D_RIGHT;
                else if (bus.btn_left && dir_ref != D_RIGHT)  pend_d = D_LEFT;
                else if (bus.btn_up && dir_ref != D_DOWN)     pend_d = D_UP;
                else if (bus.btn_down && dir_ref != D_UP)     pend_d = D_DOWN;
                if (tick) begin
                    dir_d = pend_q;
                    if (hit) begin
                        state_d = S_DEAD;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nx;
                        seg_y_d[0] = ny;
                        if (eat) begin
                            food_eaten_d = 1'b1;
                            if (len_q != L_MAX) len_d = len_q + LW'(1);
                        end
                    end
                end
            end
            S_DEAD: begin
                if (bus.start) begin
                    state_d = S_IDLE;
                    dir_d   = D_UP;
                    pend_d  = D_UP;
                    cnt_d   = '0;
                    len_d   = LW'(1);
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = X_HOME;
                        seg_y_d[i] = Y_HOME;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        snake_hit = 1'b0;
        head_hit  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (cell_hit(PW'(bus.x_pos), PW'(seg_x_q[i])) && cell_hit(PW'(bus.y_pos), PW'(seg_y_q[i]))) begin
                if (LW'(i) < len_q) snake_hit = 1'b1;
                if (i == 0)         head_hit  = 1'b1;
            end
        end
        snake_pix_d = (state_q != S_IDLE) && snake_hit;
        head_pix_d  = (state_q != S_IDLE) && head_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dir_q        <= D_UP;
            pend_q       <= D_UP;
            cnt_q        <= '0;
            len_q        <= LW'(1);
            food_eaten_q <= 1'b0;
            snake_pix_q  <= 1'b0;
            head_pix_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= X_HOME;
                seg_y_q[i] <= Y_HOME;
            end
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            food_eaten_q <= food_eaten_d;
            snake_pix_q  <= snake_pix_d;
            head_pix_q   <= head_pix_d;
            seg_x_q      <= seg_x_d;
            seg_y_q      <= seg_y_d;
        end
    end

    assign bus.food_eaten = food_eaten_q;
    assign bus.game_over  = (state_q == S_DEAD);
    assign bus.length     = len_q;
    assign bus.snake_pix  = snake_pix_q;
    assign bus.head_pix   = head_pix_q;
endmodule

// File: doc/snake_core.md
SNAKE_CORE -- requirements
Module: snake_core

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 16, maximum segment count (2..64).
REQ-002 SHALL provide parameter GRID_W, default 64, playfield width in cells.
REQ-003 SHALL provide parameter GRID_H, default 48, playfield height in cells.
REQ-004 SHALL provide parameter CELL, default 10, cell edge in pixels.
REQ-005 SHALL provide parameter STEP_CYCLES, default 20000000, clk cycles per movement step (>=4).
REQ-006 SHALL provide port clk  in  1  system clock; all state on rising edge.
REQ-007 SHALL provide port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL provide ports btn_right, btn_left, btn_up, btn_down  in  1 each  direction requests, level.
REQ-009 SHALL provide port start  in  1  begins/restarts a game.
REQ-010 SHALL provide ports food_x  in  clog2(GRID_W), food_y  in  clog2(GRID_H)  food cell.
REQ-011 SHALL provide ports x_pos  in  10, y_pos  in  10  current VGA pixel.
REQ-012 SHALL provide port food_eaten  out  1  one-cycle pulse on eating.
REQ-013 SHALL provide port game_over  out  1  high in DEAD state.
REQ-014 SHALL provide port length  out  clog2(MAX_LEN+1)  active segment count.
REQ-015 SHALL provide ports snake_pix, head_pix  out  1 each  pixel hit on body / head, registered.

Function
REQ-016 SHALL keep segment coordinates in cell units; segment 0 is the head.
REQ-017 SHALL run step counter 0..STEP_CYCLES-1 only in RUN; tick asserted when counter = STEP_CYCLES-1, counter wraps to 0 same cycle.
REQ-018 SHALL implement FSM IDLE -> RUN on start; RUN -> DEAD on self-collision; DEAD -> IDLE on start, reloading reset values of segments, length, direction, counter.
REQ-019 SHALL latch a pending direction every cycle from buttons, priority right > left > up > down; a request opposite to the committed direction is ignored.
REQ-020 SHALL commit pending direction only on tick, so two presses within one step cannot reverse the snake.
REQ-021 SHALL compute next head on tick: right x+1, left x-1, up y-1, down y+1, wrapping GRID_W-1<->0 and GRID_H-1<->0.
REQ-022 SHALL detect eat when next head equals (food_x, food_y).
REQ-023 SHALL detect collision when next head equals segment i for 1 <= i < length-1 without eat, or 1 <= i < length with eat (vacating tail excluded).
REQ-024 SHALL on tick without collision shift segment i <= segment i-1 for all i, head <= next head.
REQ-025 SHALL on eat pulse food_eaten in the cycle after tick and increment length, saturating at MAX_LEN (pulse still issued at saturation).
REQ-026 SHALL on collision enter DEAD without moving; game_over high from the next cycle until exit from DEAD.
REQ-027 SHALL ignore buttons in IDLE and DEAD; start ignored in RUN.
REQ-028 SHALL assert snake_pix one cycle after (x_pos, y_pos) lies in [seg*CELL, seg*CELL+CELL-1] inclusive on both axes for any segment index < length.
REQ-029 SHALL assert head_pix under the same rule for segment 0 only; both outputs 0 in IDLE.

Reset
REQ-030 SHALL on rst: state IDLE, counter 0, direction up (committed and pending), length 1, all segments (GRID_W/2, GRID_H/2), food_eaten 0, game_over 0, snake_pix 0, head_pix 0.
REQ-031 SHALL apply rst mid-step or mid-DEAD immediately, with no residual food_eaten pulse.

Verification
REQ-032 SHALL cover: reset, start, no buttons, STEP_CYCLES=4 -> head (32,24) to (32,23) after 4 cycles, length 1.
REQ-033 SHALL cover: head (63,10) moving right, one tick -> head (0,10); head (5,0) moving up -> (5,47).
REQ-034 SHALL cover: food at next head cell, length 3 -> food_eaten one-cycle pulse, length 4, old tail retained.
REQ-035 SHALL cover: moving up, btn_left then btn_down within one step -> commits left, never down.
REQ-036 SHALL cover: length 5 in square loop into own body -> DEAD, game_over 1, segments frozen; start -> IDLE, length 1.
REQ-037 SHALL cover: head (3,4), CELL=10 -> x_pos 30..39, y_pos 40..49 give head_pix 1 one cycle later; x_pos 40 gives 0.
